mem_port_arbiter: RTL

Round-robin arbiter and sequencer that shares the single-port 2K x 16 validator memory among NUM_REQ requesters. Each requester issues a read or write with a valid/ready handshake. The block drives the memory's one-cycle wr_en/rd_en strobes, waits out the memory's busy cycle, and returns a per-requester completion pulse with read data. It sits between the neural-engine client units and the validator memory, and is the only master on the memory port.

---
 rtl/mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Round-robin arbiter and sequencer that shares the single-port 2K x 16
// validator memory among NUM_REQ requesters. Each requester issues a read or
// write through a valid/ready handshake; the block issues a one-cycle
// mem_wr_en/mem_rd_en strobe, waits out the memory's busy cycle and returns a
// one-cycle, one-hot completion pulse carrying read data (or a timeout error).
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   TIMEOUT  WAIT cycles allowed for a read's mem_output_ready (1..15)
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid         per-requester request pending
//   req_write         per-requester 1 = write, 0 = read
//   req_addr          packed 11-bit addresses, requester i at [i*11 +: 11]
//   req_wdata         packed 16-bit write data, requester i at [i*16 +: 16]
//   req_ready         one-hot combinational handshake accept
//   rsp_valid         one-hot one-cycle completion pulse
//   rsp_rdata         read data (0 for writes and errors), valid with rsp_valid
//   rsp_err           read timed out, valid with rsp_valid
//   busy              sequencer not idle
//   mem_wr_en/rd_en   memory strobes, one cycle, never both
//   mem_address       memory address
//   mem_data_in       memory write data
//   mem_data_out      memory read data
//   mem_output_ready  memory read-data-valid pulse (ignored outside WAIT)

module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*11-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [10:0]           mem_address,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  input  logic                  mem_output_ready
);

  localparam int          PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ     = NUM_REQ;
  localparam logic [3:0]  TMO_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  // Arbitration
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      win_idx;
  logic               win_found;
  int unsigned        scan_idx;
  logic [NUM_REQ-1:0] grant_1h;

  // Selected request fields of the current winner
  logic               sel_write;
  logic [10:0]        sel_addr;
  logic [15:0]        sel_wdata;

  // Latched transaction
  logic [PW-1:0]      owner;
  logic [NUM_REQ-1:0] owner_1h;
  logic               lat_write;
  logic [10:0]        lat_addr;
  logic [15:0]        lat_wdata;

  // WAIT bookkeeping
  logic [3:0]         tmo_cnt;
  logic               wait_tmo;
  logic               wait_done;

  // Registered response
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0]        rsp_rdata_q;
  logic               rsp_err_q;

  // First valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!win_found && req_valid[PW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = PW'(scan_idx);
      end
    end
  end

  // Decode winner / owner indices and mux out the winner's request fields.
  always_comb begin
    grant_1h  = '0;
    owner_1h  = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        grant_1h[i] = 1'b1;
        sel_write   = req_write[i];
        sel_addr    = req_addr[i*11 +: 11];
        sel_wdata   = req_wdata[i*16 +: 16];
      end
      if (owner == PW'(i)) begin
        owner_1h[i] = 1'b1;
      end
    end
  end

  // A write finishes after its single WAIT cycle. A read finishes on
  // mem_output_ready, or times out once TIMEOUT WAIT cycles have gone by.
  always_comb begin
    wait_tmo  = !lat_write && !mem_output_ready && (tmo_cnt == TMO_LAST);
    wait_done = lat_write || mem_output_ready || wait_tmo;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. req_ready is masked during reset so no grant is shown in a
  // cycle whose handshake the reset is about to discard.
  always_comb begin
    req_ready = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && !reset) begin
          req_ready = grant_1h;
        end
      end
      ISSUE: begin
        mem_wr_en = lat_write;
        mem_rd_en = !lat_write;
      end
      default: ;
    endcase
  end

  assign busy        = (state != IDLE);
  assign mem_address = lat_addr;
  assign mem_data_in = lat_wdata;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

  // Datapath: latch the winner, count WAIT cycles, build the response.
  // The response registers default to zero every cycle so rsp_valid is a
  // single-cycle pulse landing in the IDLE cycle after WAIT exits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      owner       <= '0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      tmo_cnt     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            owner     <= win_idx;
            lat_write <= sel_write;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            rr_ptr    <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (wait_done) begin
            rsp_valid_q <= owner_1h;
            rsp_rdata_q <= (!lat_write && mem_output_ready) ? mem_data_out : '0;
            rsp_err_q   <= wait_tmo;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
